// File: rtl/config_read_fifo.sv
// Stream-to-register bridge: a DEPTH-entry FIFO filled from a ready/valid stream and drained by config reads.
// Define CONFIG_READ_FIFO_PEEK_EN to claim ADDR+2 as a non-destructive PEEK of the head word.
module config_read_fifo #(
    parameter int ADDR       = 0,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 64,
    parameter int CFG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp,
    output logic [CFG_WIDTH-1:0]  rd_data,
    output logic [CNT_W-1:0]      level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  underflow;
    logic                  underflow_next;
    logic                  hit_data;
    logic                  hit_status;
    logic                  hit_peek;
    logic                  do_push;
    logic                  do_pop;
    logic                  fifo_empty;
    logic [CFG_WIDTH-1:0]  head_ext;
    logic [CFG_WIDTH-1:0]  resp_data_next;

    always_comb begin
        hit_data   = rd_req && (rd_addr == ADDR_WIDTH'(ADDR));
        hit_status = rd_req && (rd_addr == ADDR_WIDTH'(ADDR + 1));
`ifdef CONFIG_READ_FIFO_PEEK_EN
        hit_peek   = rd_req && (rd_addr == ADDR_WIDTH'(ADDR + 2));
`else
        hit_peek   = 1'b0;
`endif
    end

    // in_ready is registered, so a pop while full never lets a push through in the same cycle.
    always_comb begin
        fifo_empty = (count == '0);
        do_push    = in_valid && in_ready;
        do_pop     = hit_data && !fifo_empty;

        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end

        underflow_next = underflow;
        if (hit_status) begin
            underflow_next = 1'b0;
        end
        if (hit_data && fifo_empty) begin
            underflow_next = 1'b1;
        end
    end

    // Status reports the count and underflow as they stood before this cycle's updates.
    always_comb begin
        head_ext = '0;
        head_ext[DATA_WIDTH-1:0] = mem[rd_ptr];

        resp_data_next = '0;
        if ((hit_data || hit_peek) && !fifo_empty) begin
            resp_data_next = head_ext;
        end else if (hit_status) begin
            resp_data_next[CFG_WIDTH-1] = underflow;
            resp_data_next[CNT_W-1:0]   = count;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
            rd_resp   <= 1'b0;
            rd_data   <= '0;
            in_ready  <= 1'b0;
            level     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            underflow <= underflow_next;
            rd_resp   <= hit_data || hit_status || hit_peek;
            rd_data   <= resp_data_next;
            in_ready  <= (count_next != CNT_W'(DEPTH));
            level     <= count_next;
        end
    end

endmodule

// File: tb/tb_config_read_fifo.sv
// Scoreboard bench for config_read_fifo: stimulus pushes expected responses, a negedge monitor checks them.
// Honours CONFIG_READ_FIFO_PEEK_EN the same way as the design.
module tb_config_read_fifo;

    localparam int ADDR  = 16;
    localparam int DEPTH = 16;
    localparam int DW    = 64;
    localparam int CW    = 64;
    localparam int AW    = 32;
    localparam int CNT_W = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_resp;
    logic [CW-1:0] rd_data;
    logic [CNT_W-1:0] level;

    typedef struct {
        int            due;
        logic [CW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model[$];
    logic          m_uf;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    config_read_fifo #(
        .ADDR(ADDR), .DEPTH(DEPTH), .DATA_WIDTH(DW), .CFG_WIDTH(CW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_resp(rd_resp), .rd_data(rd_data), .level(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // A response is due exactly one cycle after its request; any other cycle must be silent.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checkOutput("rd_resp", {63'b0, rd_resp}, 64'd1);
            checkOutput("rd_data", rd_data, e.data);
        end else begin
            checkOutput("rd_resp_idle", {63'b0, rd_resp}, 64'd0);
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic rq, input logic [AW-1:0] a);
        logic          exp_ready;
        logic [CW-1:0] r;
        int            sz;
        @(posedge clk);
        #1;
        sz        = model.size();
        exp_ready = (sz != DEPTH);
        checkOutput("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
        in_valid = v;
        in_data  = d;
        rd_req   = rq;
        rd_addr  = a;
        if (rq) begin
            if (a == ADDR) begin
                if (sz > 0) begin
                    r = model.pop_front();
                end else begin
                    r    = '0;
                    m_uf = 1'b1;
                end
                exp_q.push_back('{cyc + 1, r});
            end else if (a == ADDR + 1) begin
                r = '0;
                r[CW-1]      = m_uf;
                r[CNT_W-1:0] = CNT_W'(sz);
                m_uf = 1'b0;
                exp_q.push_back('{cyc + 1, r});
            end
`ifdef CONFIG_READ_FIFO_PEEK_EN
            else if (a == ADDR + 2) begin
                r = (sz > 0) ? model[0] : '0;
                exp_q.push_back('{cyc + 1, r});
            end
`endif
        end
        if (v && exp_ready) begin
            model.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic checkLevel();
        checkOutput("level", {59'b0, level}, 64'(model.size()));
    endtask

    task automatic doReset(input logic immediate);
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        model.delete();
        m_uf     = 1'b0;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        #1;
        checkOutput("rst_rd_resp", {63'b0, rd_resp}, 64'd0);
        checkOutput("rst_level", {59'b0, level}, 64'd0);
        checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic          v;
        logic          rq;
        logic [AW-1:0] a;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_addr = '0; m_uf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("reset_level", {59'b0, level}, 64'd0);
        checkOutput("reset_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        @(posedge clk);

        $display("[TB] basic push then three DATA reads");
        applyStimulus(1'b1, 64'hA1, 1'b0, '0);
        applyStimulus(1'b1, 64'hA2, 1'b0, '0);
        applyStimulus(1'b1, 64'hA3, 1'b0, '0);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        idle(2);
        checkLevel();

        $display("[TB] fill to DEPTH, pop while full, refill");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 64'h100 + 64'(i), 1'b0, '0);
        idle(2);
        checkLevel();
        applyStimulus(1'b1, 64'h1FF, 1'b1, AW'(ADDR));
        applyStimulus(1'b1, 64'h1FF, 1'b0, '0);
        idle(2);
        checkLevel();
        repeat (DEPTH) applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        idle(2);
        checkLevel();

        $display("[TB] underflow and sticky status, unclaimed addresses");
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 3));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR - 1));
        applyStimulus(1'b1, 64'hB0, 1'b1, AW'(ADDR));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        idle(2);
        checkLevel();

        $display("[TB] simultaneous push/pop at count 5 and mixed traffic");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 64'hC0 + 64'(i), 1'b0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'hC8 + 64'(i), 1'b1, AW'(ADDR));
        idle(2);
        checkLevel();
        for (int i = 0; i < 40; i++) begin
            v  = ((i / 8) % 2 == 0) || (i % 3 == 0);
            rq = (i % 2 == 1) || ((i / 8) % 2 == 1);
            a  = (i % 7 == 3) ? AW'(ADDR + 1) : (i % 11 == 5) ? AW'(ADDR + 3) : AW'(ADDR);
            applyStimulus(v, 64'hD000 + 64'(i), rq, a);
        end
        idle(2);
        checkLevel();

        $display("[TB] reset with 7 words stored and a DATA request in flight");
        doReset(1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 64'hE0 + 64'(i), 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        doReset(1'b1);
        idle(1);
        checkLevel();
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
        idle(2);

`ifdef CONFIG_READ_FIFO_PEEK_EN
        $display("[TB] PEEK enabled");
        applyStimulus(1'b1, 64'hF1, 1'b0, '0);
        applyStimulus(1'b1, 64'hF2, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 2));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 2));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        idle(2);
        checkLevel();
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 2));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
`else
        $display("[TB] PEEK disabled");
        applyStimulus(1'b1, 64'hF1, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 2));
        idle(2);
        checkLevel();
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR + 1));
        applyStimulus(1'b0, '0, 1'b1, AW'(ADDR));
`endif
        idle(3);
        checkLevel();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
